// File: rtl/bombjack_dl_pkg.sv
// Shared types and constants for the Bomb Jack ROM download arbiter:
// FSM states, the address-region table, the FIFO entry layout and defaults.
package bombjack_dl_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Contiguous ROM regions; each entry is [base, last] inclusive.
  localparam int NUM_REGIONS = 4;
  localparam logic [24:0] REGION_BASE [NUM_REGIONS] = '{
    25'h00000, 25'h0E000, 25'h10000, 25'h16000
  };
  localparam logic [24:0] REGION_LAST [NUM_REGIONS] = '{
    25'h0DFFF, 25'h0FFFF, 25'h15FFF, 25'h17FFF
  };
  // First byte address beyond every region; such bytes are discarded.
  localparam logic [24:0] ADDR_LIMIT = 25'h18000;

  // One queued write, decoded at push time (27 bits).
  typedef struct packed {
    logic [1:0]  region;
    logic [16:0] offset;
    logic [7:0]  data;
  } entry_t;

  // Map a loader byte onto (region, offset). The caller filters out-of-range
  // addresses, so the "no region found" case only yields a don't-care entry.
  function automatic entry_t decode_entry(input logic [24:0] addr,
                                          input logic [7:0]  data);
    entry_t e;
    logic   found;
    e      = '0;
    e.data = data;
    found  = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found && addr <= REGION_LAST[i]) begin
        found    = 1'b1;
        e.region = 2'(i);
        e.offset = 17'(addr - REGION_BASE[i]);
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/bombjack_dl_fifo.sv
// Synchronous show-ahead FIFO of decoded write entries. The head entry is
// visible on 'head' whenever 'empty' is low; 'pop' retires it.
module bombjack_dl_fifo
  import bombjack_dl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; validity is tracked by count/pointers,
  // so clearing it would only cost reset routing.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bombjack_dl_arbiter.sv
// Download arbiter: accepts loader bytes, decodes them into ROM regions,
// queues them for the ROM targets and holds the game core in reset until
// the download has been committed and a settling period has elapsed.
module bombjack_dl_arbiter
  import bombjack_dl_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        wr_req,
  output logic [1:0]  wr_region,
  output logic [16:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic        core_reset,
  output logic        dl_done,
  output logic [7:0]  drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

  state_t        state;
  state_t        state_next;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  entry_t        head;
  entry_t        push_entry;
  logic          strobe;
  logic          in_range;
  logic          push;
  logic          drop;
  logic          pop;
  logic          load_entry;

  // Strobes only count while loading; out-of-range or overflow bytes drop.
  assign strobe     = (state == ST_LOAD) && ioctl_wr;
  assign in_range   = (ioctl_addr < ADDR_LIMIT);
  assign push       = strobe && in_range && !fifo_full;
  assign drop       = strobe && (!in_range || fifo_full);
  assign pop        = wr_ack && !fifo_empty;
  assign push_entry = decode_entry(ioctl_addr, ioctl_dout);
  assign load_entry = (state_next == ST_LOAD) && (state != ST_LOAD);

  bombjack_dl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Target-side view of the FIFO head; reset empties the FIFO asynchronously.
  assign wr_req     = !fifo_empty;
  assign wr_region  = head.region;
  assign wr_addr    = head.offset;
  assign wr_data    = head.data;
  assign ioctl_wait = (fifo_count >= CW'(DEPTH - 1));

  // State register; reset parks the FSM in HOLD so the core stays in reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_next;
  end

  // Next-state logic; a new download pre-empts DRAIN and HOLD.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    unique case (state)
      ST_IDLE:  if (ioctl_download) state_next = ST_LOAD;
      ST_LOAD:  if (!ioctl_download) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (ioctl_download)  state_next = ST_LOAD;
        else if (fifo_empty) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (ioctl_download)            state_next = ST_LOAD;
        else if (hold_cnt <= HW'(1))   state_next = ST_IDLE;
      end
      default: state_next = ST_HOLD;
    endcase
  end

  // Output decode: the core runs only when idle.
  always_comb begin
    core_reset = (state != ST_IDLE);
  end

  // Hold counter: HOLD lasts HOLD_CYCLES cycles, reaching 0 on exit to IDLE.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                          hold_cnt <= HOLD_INIT;
    else if (state_next == ST_LOAD)                     hold_cnt <= '0;
    else if (state == ST_DRAIN && state_next == ST_HOLD) hold_cnt <= HOLD_INIT;
    else if (state == ST_HOLD && hold_cnt != '0)        hold_cnt <= hold_cnt - 1'b1;
  end

  // Sticky completion flag, set on HOLD->IDLE and cleared by a new download.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                         dl_done <= 1'b0;
    else if (load_entry)                               dl_done <= 1'b0;
    else if (state == ST_HOLD && state_next == ST_IDLE) dl_done <= 1'b1;
  end

  // Saturating count of discarded bytes for the current download.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                              drop_count <= 8'd0;
    else if (load_entry)                    drop_count <= 8'd0;
    else if (drop && drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_bombjack_dl_arbiter.sv
// Directed bench for bombjack_dl_arbiter with hand-computed expectations.
module tb_bombjack_dl_arbiter;
  import bombjack_dl_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        wr_req;
  logic [1:0]  wr_region;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        core_reset;
  logic        dl_done;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  bombjack_dl_arbiter #(.DEPTH(4), .HOLD_CYCLES(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .wr_req         (wr_req),
    .wr_region      (wr_region),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .core_reset     (core_reset),
    .dl_done        (dl_done),
    .drop_count     (drop_count)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
  endtask

  initial begin
    logic seen_req;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    wr_ack         = 1'b0;

    // ---- Reset state ----
    tick();
    tick();
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_wr_req",     32'(wr_req), 0);
    chk("rst_wait",       32'(ioctl_wait), 0);
    chk("rst_dl_done",    32'(dl_done), 0);
    chk("rst_drop",       32'(drop_count), 0);
    chk("rst_state",      32'(dut.state), 32'(ST_HOLD));
    reset = 1'b0;

    // ---- No download: core_reset held 16 cycles, then released ----
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("hold_core_reset_%0d", i), 32'(core_reset), 1);
      tick();
    end
    chk("hold_released", 32'(core_reset), 0);
    chk("hold_dl_done",  32'(dl_done), 1);

    // ---- Download two bytes across the region 0/1 boundary, ack tied high ----
    wr_ack         = 1'b1;
    ioctl_download = 1'b1;
    tick();
    chk("load_state",   32'(dut.state), 32'(ST_LOAD));
    chk("load_dl_done", 32'(dl_done), 0);
    strobe(25'h0DFFF, 8'hAA);
    tick();
    strobe(25'h0E000, 8'h55);
    chk("b0_req",    32'(wr_req), 1);
    chk("b0_region", 32'(wr_region), 0);
    chk("b0_addr",   32'(wr_addr), 32'h0DFFF);
    chk("b0_data",   32'(wr_data), 32'hAA);
    tick();
    ioctl_wr = 1'b0;
    chk("b1_req",    32'(wr_req), 1);
    chk("b1_region", 32'(wr_region), 1);
    chk("b1_addr",   32'(wr_addr), 32'h00000);
    chk("b1_data",   32'(wr_data), 32'h55);
    tick();
    chk("drained_req", 32'(wr_req), 0);

    // ---- Out-of-range write is dropped, never requested ----
    strobe(25'h18000, 8'h77);
    tick();
    ioctl_wr = 1'b0;
    chk("oor_req",  32'(wr_req), 0);
    chk("oor_drop", 32'(drop_count), 1);
    tick();
    chk("oor_req_later", 32'(wr_req), 0);

    // ---- Write after download falls is ignored ----
    ioctl_download = 1'b0;
    tick();
    chk("drain_state", 32'(dut.state), 32'(ST_DRAIN));
    strobe(25'h00100, 8'h11);
    tick();
    ioctl_wr = 1'b0;
    chk("late_wr_drop",  32'(drop_count), 1);
    chk("late_wr_req",   32'(wr_req), 0);
    chk("hold_state",    32'(dut.state), 32'(ST_HOLD));
    chk("hold1_core",    32'(core_reset), 1);

    // ---- Restart download in HOLD cycle 5 ----
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("hold%0d_core", i), 32'(core_reset), 1);
    end
    ioctl_download = 1'b1;
    tick();
    chk("restart_state", 32'(dut.state), 32'(ST_LOAD));
    chk("restart_done",  32'(dl_done), 0);
    chk("restart_drop",  32'(drop_count), 0);
    chk("restart_core",  32'(core_reset), 1);

    // ---- Backpressure with ack held low: 5 strobes, 5th dropped ----
    wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(25'h00100 + 25'(i), 8'h10 + 8'(i));
      tick();
      chk($sformatf("bp_wait_%0d", i + 1), 32'(ioctl_wait), (i >= 2) ? 1 : 0);
    end
    ioctl_wr = 1'b0;
    chk("bp_drop",      32'(drop_count), 1);
    chk("bp_head_addr", 32'(wr_addr), 32'h00100);
    chk("bp_head_data", 32'(wr_data), 32'h10);
    tick();
    chk("bp_stable_addr", 32'(wr_addr), 32'h00100);

    // Pop two entries back-to-back: no bubble between them.
    wr_ack = 1'b1;
    tick();
    chk("pop1_req",  32'(wr_req), 1);
    chk("pop1_addr", 32'(wr_addr), 32'h00101);
    tick();
    wr_ack = 1'b0;
    chk("pop2_req",  32'(wr_req), 1);
    chk("pop2_addr", 32'(wr_addr), 32'h00102);
    chk("pop2_wait", 32'(ioctl_wait), 0);

    // ---- Asynchronous reset with 2 queued entries ----
    #2;
    reset = 1'b1;
    #1;
    chk("areset_req",  32'(wr_req), 0);
    chk("areset_core", 32'(core_reset), 1);
    chk("areset_drop", 32'(drop_count), 0);
    #2;
    reset          = 1'b0;
    ioctl_download = 1'b0;
    wr_ack         = 1'b1;
    seen_req       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_req) seen_req = 1'b1;
    end
    chk("post_reset_no_stale", 32'(seen_req), 0);
    chk("post_reset_core",     32'(core_reset), 0);
    chk("post_reset_done",     32'(dl_done), 1);

    // ---- drop_count saturates at 255 ----
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 260; i++) begin
      strobe(25'h1FFFFFF, 8'(i));
      tick();
    end
    ioctl_wr = 1'b0;
    chk("drop_saturated", 32'(drop_count), 255);
    chk("drop_no_req",    32'(wr_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bombjack_dl_arbiter.md
BOMBJACK_DL_ARBITER -- requirements
Module: bombjack_dl_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: write-FIFO entries, power of two, at least 2.
REQ-002 Parameter HOLD_CYCLES, default 16: number of core-reset extension cycles after the last byte is committed.
REQ-003 clk_sys  in  1  single system clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ioctl_download  in  1  a download is active while high.
REQ-006 ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 ioctl_addr  in  25  byte address.
REQ-008 ioctl_dout  in  8  byte data.
REQ-009 ioctl_wait  out  1  backpressure to the loader.
REQ-010 wr_req  out  1  write request to the ROM targets.
REQ-011 wr_region  out  2  target region index.
REQ-012 wr_addr  out  17  offset within the region.
REQ-013 wr_data  out  8  write data.
REQ-014 wr_ack  in  1  target accepted the current request.
REQ-015 core_reset  out  1  holds the game core in reset.
REQ-016 dl_done  out  1  sticky flag: download completed.
REQ-017 drop_count  out  8  saturating count of discarded bytes.

Function
REQ-018 States SHALL be IDLE, LOAD, DRAIN and HOLD, one-hot or encoded.
- IDLE -> LOAD on ioctl_download=1.
- LOAD -> DRAIN on ioctl_download=0.
- DRAIN -> HOLD when the FIFO is empty and wr_req=0; the hold counter loads HOLD_CYCLES.
- HOLD -> IDLE when the counter reaches 0.
- ioctl_download=1 in DRAIN or HOLD -> LOAD; the counter is cleared.
REQ-019 core_reset SHALL be 1 in LOAD, DRAIN and HOLD, and 0 only in IDLE.
REQ-020 dl_done SHALL set on the HOLD->IDLE transition and clear on entry to LOAD.
REQ-021 Region decode SHALL be taken from the package table:
- region 0: 0x00000-0x0DFFF
- region 1: 0x0E000-0x0FFFF
- region 2: 0x10000-0x15FFF
- region 3: 0x16000-0x17FFF
- wr_addr = ioctl_addr minus the region base.
REQ-022 Bytes with ioctl_addr >= 0x18000, or ioctl_wr while the FIFO is full, SHALL be discarded; drop_count increments by 1 per byte and saturates at 255.
REQ-023 ioctl_wr outside LOAD SHALL be ignored and SHALL NOT be counted.
REQ-024 ioctl_wait SHALL be combinationally 1 when FIFO occupancy >= DEPTH-1, otherwise 0.
REQ-025 A byte pushed in cycle N into an empty FIFO SHALL appear on wr_req/wr_* in cycle N+1.
REQ-026 wr_req and wr_* SHALL stay stable until the cycle in which wr_ack=1; the entry is popped in that cycle.
REQ-027 The next entry SHALL be presented in the cycle after the ack, with no bubble.
REQ-028 wr_ack while wr_req=0 SHALL be ignored.
REQ-029 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-030 Region and offset SHALL be computed at push time and stored with the byte (27 bits per entry).
REQ-031 drop_count SHALL clear on entry to LOAD.

Reset
REQ-032 On reset the block SHALL enter HOLD with the counter at HOLD_CYCLES, with:
- core_reset=1, FIFO empty
- wr_req=0, ioctl_wait=0
- dl_done=0, drop_count=0
REQ-033 Reset during LOAD or DRAIN SHALL discard FIFO contents and any pending request immediately.

Structure
REQ-034 Package bombjack_dl_pkg SHALL hold:
- the state enum
- the region base/limit constants
- the entry struct {region, offset, data}
- the default DEPTH and HOLD_CYCLES
REQ-035 The FIFO SHALL be a sub-module, bombjack_dl_fifo (synchronous, show-ahead, with count output); decode and the state machine stay in the top module.

Verification
REQ-036 Reset released, no download: core_reset stays 1 for 16 cycles, then 0; dl_done=1.
REQ-037 Download of bytes 0x0DFFF=0xAA and 0x0E000=0x55, with wr_ack tied high: wr_region=0, wr_addr=0x0DFFF, data 0xAA, then region=1, addr=0x00000, data 0x55, on consecutive cycles.
REQ-038 wr_ack held 0 while 5 strobes are sent (DEPTH=4): ioctl_wait=1 after the 3rd push; the 5th byte is dropped; drop_count=1.
REQ-039 Write to 0x18000: no wr_req occurs; drop_count=1. A write after ioctl_download falls: ignored, drop_count unchanged.
REQ-040 New download starts in HOLD cycle 5: state goes to LOAD, dl_done=0, drop_count=0, core_reset stays 1 throughout.
REQ-041 Reset asserted while 2 entries are queued and wr_req=1: wr_req=0 in the same cycle; after release no stale writes are issued.
